fp32_mul_core: RTL and testbench
================================

// Module: fp32_mul_core
// PURPOSE
//  - Multi-cycle IEEE-754 single-precision multiplier; sits directly downstream of the AXI4-lite
//    operand register block: consumes operands a/b, produces the 32-bit result read back as fpu_result.
//  - Round-to-nearest-even; subnormal inputs/outputs flushed to signed zero; valid/ready on both sides.
// PARAMETERS
//  EXP_W   8             exponent field width (fixed fp32; 8 only)
//  FRAC_W  23            fraction field width (fixed fp32; 23 only)
//  QNAN    32'h7FC0_0000 canonical quiet NaN emitted for every NaN result
// PORTS
//  aclk       in   1   clock; all state on rising edge
//  areset     in   1   reset, asynchronous, active-high
//  a          in   32  operand A (fp32), sampled on input handshake
//  b          in   32  operand B (fp32), sampled on input handshake
//  in_valid   in   1   operands valid
//  in_ready   out  1   core idle, can accept
//  result     out  32  product (fp32), held until next result completes
//  out_valid  out  1   result valid
//  out_ready  in   1   consumer accepts result
//  flags      out  4   {invalid,overflow,underflow,inexact}; only with FPU_MUL_FLAGS_EN
// BEHAVIOUR
//  - Reset: state=IDLE, result=0, out_valid=0, in_ready=1, flags=0. Async assert; clears mid-op work.
//  - FSM IDLE->MUL->NORM->RND->DONE->IDLE. in_ready=(IDLE); out_valid=(DONE).
//    IDLE: on in_valid, latch a/b, go MUL. MUL: unpack, classify, 24x24->48b mantissa product,
//    exp = ea+eb-127 in 10b signed. NORM: if prod[47] shift right 1, exp+1; take guard, round, sticky.
//    RND: RNE (inc if G&(R|S|lsb)); carry out of mantissa -> exp+1; pack into result. DONE: hold until
//    out_ready, then IDLE. Latency: accept edge -> out_valid high 4 edges later; 1 op in flight max.
//  - in_valid during MUL..DONE ignored (in_ready=0); operands never re-sampled mid-op.
//  - out_ready low: result/out_valid stable indefinitely. out_ready high in IDLE: no effect.
//  - Sign = sa^sb for all non-NaN results.
//  - Specials (decided in MUL, bypass arithmetic, still take full 4-cycle latency):
//    any NaN -> QNAN; Inf*0 -> QNAN (invalid); Inf*finite/Inf -> signed Inf; zero/subnormal operand -> signed 0.
//  - Overflow: final exp >= 255 -> signed Inf (overflow, inexact).
//  - Underflow: final exp <= 0 -> signed 0 (underflow, inexact if product nonzero).
//  - inexact = G|R|S after normalisation, or as above.
// CONFIGURATION
//  - FPU_MUL_FLAGS_EN defined: flags port exists, registered in RND, valid with out_valid, held to next op.
//  - Undefined: no flags port, no flag logic; result/timing identical.
// STRUCTURE
//  - fpu_pkg: EXP_W/FRAC_W/BIAS(127), QNAN/PINF constants, fsm state typedef, flag bit indices.
//  - Sub-module fp32_unpack: splits sign/exp/mantissa (hidden bit), classifies zero/inf/nan/sub; one per operand.
// TESTING
//  - 3FC00000 * 40000000 -> 40400000, out_valid 4 edges after accept, flags 0.
//  - C0000000 * 40400000 -> C0C00000; 3F800001*3F800001 -> 3F800002, inexact=1 (RNE).
//  - 7F000000 * 7F000000 -> 7F800000, overflow+inexact; 00800000*00800000 -> 00000000, underflow+inexact.
//  - 7F800000 * 00000000 -> 7FC00000 invalid; 7FC12345 * 3F800000 -> 7FC00000; 80000000*3F800000 -> 80000000.
//  - out_ready low 10 cycles in DONE: result/out_valid stable, in_ready 0, new in_valid ignored.
//  - areset pulsed during NORM: out_valid 0, result 0, in_ready 1 immediately; next op correct.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared constants and types for the fp32 multiplier core.
package fpu_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {StIdle, StMul, StNorm, StRnd, StDone} state_e;

    // Result class decided up front; SpNone takes the arithmetic path
    typedef enum logic [2:0] {SpNone, SpNan, SpInvalid, SpInf, SpZero} special_e;

    // Bit positions inside flags = {invalid, overflow, underflow, inexact}
    localparam int unsigned FLAG_INVALID   = 3;
    localparam int unsigned FLAG_OVERFLOW  = 2;
    localparam int unsigned FLAG_UNDERFLOW = 1;
    localparam int unsigned FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp32_unpack.sv
// Splits an fp32 word into sign/exponent/mantissa (with hidden bit) and classifies it.
module fp32_unpack
    import fpu_pkg::*;
(
    input  logic [EXP_W+FRAC_W:0] op,
    output logic                  sign,
    output logic [EXP_W-1:0]      exp_field,
    output logic [FRAC_W:0]       mant,
    output logic                  is_zero,
    output logic                  is_sub,
    output logic                  is_inf,
    output logic                  is_nan
);

    logic [FRAC_W-1:0] frac;
    logic              exp_max;
    logic              exp_min;
    logic              frac_nz;

    // Field extraction and classification
    always_comb begin
        sign      = op[EXP_W+FRAC_W];
        exp_field = op[EXP_W+FRAC_W-1:FRAC_W];
        frac      = op[FRAC_W-1:0];
        exp_max   = &exp_field;
        exp_min   = ~|exp_field;
        frac_nz   = |frac;
        mant      = {~exp_min, frac};
        is_zero   = exp_min & ~frac_nz;
        is_sub    = exp_min & frac_nz;
        is_inf    = exp_max & ~frac_nz;
        is_nan    = exp_max & frac_nz;
    end

endmodule

// File: rtl/fp32_mul_core.sv
// Multi-cycle fp32 multiplier, round-to-nearest-even, subnormals flushed to signed zero.
// Optional exception flags port enabled by defining FPU_MUL_FLAGS_EN.
module fp32_mul_core
    import fpu_pkg::*;
(
    input  logic        aclk,
    input  logic        areset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] result,
    output logic        out_valid,
    input  logic        out_ready
`ifdef FPU_MUL_FLAGS_EN
    ,
    output logic [3:0]  flags
`endif
);

    state_e             state_q;
    logic [31:0]        a_q, b_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;
    logic [47:0]        prod_q;
    special_e           special_q;
    logic [23:0]        mant_q;
    logic               g_q, r_q, s_q;
    logic [31:0]        result_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic               sa, sb;
    logic [7:0]         ea, eb;
    logic [23:0]        ma, mb;
    logic               za, zb, suba, subb, ia, ib, na, nb;

    logic               sign_d;
    logic signed [9:0]  exp_sum_d;
    logic [47:0]        prod_d;
    special_e           special_d;

    logic [23:0]        mant_n;
    logic               g_n, r_n, s_n;
    logic signed [9:0]  exp_n;

    logic               inc;
    logic [24:0]        mant_r;
    logic signed [9:0]  exp_r;
    logic [22:0]        frac_r;
    logic [31:0]        result_d;

    fp32_unpack u_unpack_a (
        .op        (a_q),
        .sign      (sa),
        .exp_field (ea),
        .mant      (ma),
        .is_zero   (za),
        .is_sub    (suba),
        .is_inf    (ia),
        .is_nan    (na)
    );

    fp32_unpack u_unpack_b (
        .op        (b_q),
        .sign      (sb),
        .exp_field (eb),
        .mant      (mb),
        .is_zero   (zb),
        .is_sub    (subb),
        .is_inf    (ib),
        .is_nan    (nb)
    );

    // MUL stage: sign, biased exponent sum, full mantissa product and special-case class
    always_comb begin
        sign_d    = sa ^ sb;
        exp_sum_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(BIAS));
        prod_d    = {24'd0, ma} * {24'd0, mb};
        if (na || nb) begin
            special_d = SpNan;
        end else if ((ia && (zb || subb)) || ((za || suba) && ib)) begin
            special_d = SpInvalid;
        end else if (ia || ib) begin
            special_d = SpInf;
        end else if (za || zb || suba || subb) begin
            special_d = SpZero;
        end else begin
            special_d = SpNone;
        end
    end

    // NORM stage: product of two [1,2) mantissas lies in [1,4); bring it back to [1,2)
    always_comb begin
        if (prod_q[47]) begin
            mant_n = prod_q[47:24];
            g_n    = prod_q[23];
            r_n    = prod_q[22];
            s_n    = |prod_q[21:0];
            exp_n  = exp_q + 10'sd1;
        end else begin
            mant_n = prod_q[46:23];
            g_n    = prod_q[22];
            r_n    = prod_q[21];
            s_n    = |prod_q[20:0];
            exp_n  = exp_q;
        end
    end

    // RND stage: nearest-even increment, renormalise on carry, range check and pack
    always_comb begin
        inc    = g_q & (r_q | s_q | mant_q[0]);
        mant_r = {1'b0, mant_q} + {24'd0, inc};
        exp_r  = exp_q + $signed({9'd0, mant_r[24]});
        frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
        case (special_q)
            SpNan, SpInvalid: result_d = QNAN;
            SpInf:            result_d = {sign_q, PINF[30:0]};
            SpZero:           result_d = {sign_q, 31'd0};
            default: begin
                if (exp_r >= 10'sd255) begin
                    result_d = {sign_q, PINF[30:0]};
                end else if (exp_r <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                end else begin
                    result_d = {sign_q, exp_r[7:0], frac_r};
                end
            end
        endcase
    end

`ifdef FPU_MUL_FLAGS_EN
    logic [3:0] flags_q;
    logic [3:0] flags_d;

    // Exception flags computed alongside the packed result
    always_comb begin
        flags_d = 4'd0;
        case (special_q)
            SpInvalid: flags_d[FLAG_INVALID] = 1'b1;
            SpNone: begin
                if (exp_r >= 10'sd255) begin
                    flags_d[FLAG_OVERFLOW] = 1'b1;
                    flags_d[FLAG_INEXACT]  = 1'b1;
                end else if (exp_r <= 10'sd0) begin
                    // Both operands are normal here, so the true product is nonzero
                    flags_d[FLAG_UNDERFLOW] = 1'b1;
                    flags_d[FLAG_INEXACT]   = 1'b1;
                end else begin
                    flags_d[FLAG_INEXACT] = g_q | r_q | s_q;
                end
            end
            default: flags_d = 4'd0;
        endcase
    end

    // Flags register: updated with the result, held until the next operation completes
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            flags_q <= 4'd0;
        end else if (state_q == StRnd) begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`endif

    // Control FSM with all pipeline registers and registered handshake outputs
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= StIdle;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            sign_q      <= 1'b0;
            exp_q       <= 10'sd0;
            prod_q      <= 48'd0;
            special_q   <= SpNone;
            mant_q      <= 24'd0;
            g_q         <= 1'b0;
            r_q         <= 1'b0;
            s_q         <= 1'b0;
            result_q    <= 32'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        in_ready_q <= 1'b0;
                        state_q    <= StMul;
                    end
                end
                StMul: begin
                    sign_q    <= sign_d;
                    exp_q     <= exp_sum_d;
                    prod_q    <= prod_d;
                    special_q <= special_d;
                    state_q   <= StNorm;
                end
                StNorm: begin
                    mant_q  <= mant_n;
                    g_q     <= g_n;
                    r_q     <= r_n;
                    s_q     <= s_n;
                    exp_q   <= exp_n;
                    state_q <= StRnd;
                end
                StRnd: begin
                    result_q    <= result_d;
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_fp32_mul_core.sv
// Self-checking bench for fp32_mul_core: directed vectors, randomized ops against an
// integer-arithmetic reference model, backpressure, mid-operation reset, back-to-back ops.
module tb_fp32_mul_core;

    logic        aclk;
    logic        areset;
    logic [31:0] a;
    logic [31:0] b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  flags;

    int checks;
    int errors;

    // Edges after the accept edge until out_valid is seen (accept edge is the first of four)
    localparam int LAT = 3;

    fp32_mul_core dut (
        .aclk      (aclk),
        .areset    (areset),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef FPU_MUL_FLAGS_EN
        ,
        .flags     (flags)
`endif
    );

`ifndef FPU_MUL_FLAGS_EN
    assign flags = 4'd0;
`endif

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: exact integer product, then nearest-even by comparing the discarded part to half
    function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] r, output logic [3:0] f);
        int ex, ey, e, sh;
        logic s, nx, ny, ix, iy, zx, zy, inx;
        longint unsigned p, m, rem, half;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        s  = x[31] ^ y[31];
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        f  = 4'b0000;
        if (nx || ny) begin
            r = 32'h7FC0_0000;
        end else if ((ix && zy) || (zx && iy)) begin
            r = 32'h7FC0_0000;
            f = 4'b1000;
        end else if (ix || iy) begin
            r = {s, 8'hFF, 23'd0};
        end else if (zx || zy) begin
            r = {s, 31'd0};
        end else begin
            p = {41'd0, 1'b1, x[22:0]} * {41'd0, 1'b1, y[22:0]};
            e = ex + ey - 127;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end else begin
                sh = 23;
            end
            m    = p >> sh;
            rem  = p - (m << sh);
            half = 64'd1 << (sh - 1);
            inx  = (rem != 0);
            if ((rem > half) || ((rem == half) && m[0])) m = m + 1;
            if (m == (64'd1 << 24)) begin
                m = m >> 1;
                e = e + 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'd0};
                f = 4'b0101;
            end else if (e <= 0) begin
                r = {s, 31'd0};
                f = 4'b0011;
            end else begin
                r = {s, 8'(e), 23'(m)};
                f = {3'b000, inx};
            end
        end
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] specials [9];
        int sel;
        specials = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000,
                     32'h7F80_0001, 32'h0000_0001, 32'h007F_FFFF, 32'h3F80_0000};
        sel = int'($urandom_range(0, 9));
        if (sel <= 1) return $urandom;
        if (sel == 2) return specials[$urandom_range(0, 8)];
        if (sel <= 4) return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
        return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
    endfunction

    // Drives one operation and collects its result; lat is -1 if out_valid never rose
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r, output logic [3:0] f, output int lat);
        int k;
        lat = -1;
        @(negedge aclk);
        a = x;
        b = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge aclk);
            k++;
        end
        @(posedge aclk);
        #1 in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge aclk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        r = result;
        f = flags;
        @(negedge aclk);
        out_ready = 1'b1;
        @(posedge aclk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        areset    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = 32'd0;
        b = 32'd0;
        repeat (3) @(posedge aclk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (result !== 32'd0) begin
            errors++;
            $display("FAIL reset_result got %h want 00000000", result);
        end
`ifdef FPU_MUL_FLAGS_EN
        checks++;
        if (flags !== 4'd0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", flags);
        end
`endif
        @(negedge aclk);
        areset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] vr [10];
        logic [3:0]  vf [10];
        logic [31:0] r;
        logic [3:0]  f;
        int lat;
        va = '{32'h3FC00000, 32'hC0000000, 32'h3F800001, 32'h7F000000, 32'h00800000,
               32'h7F800000, 32'h7FC12345, 32'h80000000, 32'hFF800000, 32'h3F800001};
        vb = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h7F000000, 32'h00800000,
               32'h00000000, 32'h3F800000, 32'h3F800000, 32'h40000000, 32'h3FC00000};
        vr = '{32'h40400000, 32'hC0C00000, 32'h3F800002, 32'h7F800000, 32'h00000000,
               32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'hFF800000, 32'h3FC00002};
        vf = '{4'b0000, 4'b0000, 4'b0001, 4'b0101, 4'b0011,
               4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        for (int i = 0; i < 10; i++) begin
            run_op(va[i], vb[i], r, f, lat);
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, LAT);
            end
            checks++;
            if (r !== vr[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] %h*%h got %h want %h", i, va[i], vb[i],
                         r, vr[i]);
            end
`ifdef FPU_MUL_FLAGS_EN
            checks++;
            if (f !== vf[i]) begin
                errors++;
                $display("FAIL directed_flags[%0d] got %b want %b", i, f, vf[i]);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [31:0] x, y, r, er;
        logic [3:0]  f, ef;
        int lat;
        for (int i = 0; i < 300; i++) begin
            x = rand_op();
            y = rand_op();
            ref_mul(x, y, er, ef);
            run_op(x, y, r, f, lat);
            checks++;
            if (r !== er || lat != LAT) begin
                errors++;
                $display("FAIL random_result[%0d] %h*%h got %h lat %0d want %h lat %0d",
                         i, x, y, r, lat, er, LAT);
            end
`ifdef FPU_MUL_FLAGS_EN
            checks++;
            if (f !== ef) begin
                errors++;
                $display("FAIL random_flags[%0d] %h*%h got %b want %b", i, x, y, f, ef);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        int k;
        @(negedge aclk);
        a = 32'h3FC00000;
        b = 32'h40000000;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge aclk);
            k++;
        end
        @(posedge aclk);
        #1 in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge aclk);
            #1;
            k++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_done_timeout got out_valid %b want 1", out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            in_valid = 1'b1;
            a = $urandom;
            b = $urandom;
            @(posedge aclk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || result !== 32'h40400000 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d] got ov %b res %h ir %b want 1 40400000 0",
                         i, out_valid, result, in_ready);
            end
        end
        @(negedge aclk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge aclk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release got ov %b ir %b want 0 1", out_valid, in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge aclk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'h40400000) begin
                errors++;
                $display("FAIL idle_out_ready[%0d] got ov %b ir %b res %h want 0 1 40400000",
                         i, out_valid, in_ready, result);
            end
        end
        @(negedge aclk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        logic [3:0]  f;
        int lat, k;
        @(negedge aclk);
        a = 32'h7F000000;
        b = 32'h3F800001;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge aclk);
            k++;
        end
        @(posedge aclk);
        #1 in_valid = 1'b0;
        @(posedge aclk);
        #1 areset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_async got ov %b res %h ir %b want 0 00000000 1",
                     out_valid, result, in_ready);
        end
        @(negedge aclk);
        areset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge aclk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL midreset_quiet[%0d] got ov %b ir %b want 0 1",
                         i, out_valid, in_ready);
            end
        end
        run_op(32'hC0000000, 32'h40400000, r, f, lat);
        checks++;
        if (r !== 32'hC0C00000 || lat != LAT) begin
            errors++;
            $display("FAIL midreset_next got %h lat %0d want C0C00000 lat %0d", r, lat, LAT);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_r [$];
        logic [31:0] x, y, er, got;
        logic [3:0]  ef;
        int sent, recv, cyc;
        sent = 0;
        recv = 0;
        cyc  = 0;
        out_ready = 1'b1;
        while (recv < 20 && cyc < 2000) begin
            @(negedge aclk);
            cyc++;
            if (out_valid) begin
                got = result;
                checks++;
                if (exp_r.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got %h want no result", got);
                end else begin
                    er = exp_r.pop_front();
                    if (got !== er) begin
                        errors++;
                        $display("FAIL b2b_result[%0d] got %h want %h", recv, got, er);
                    end
                end
                recv++;
            end
            if (in_ready && sent < 20) begin
                x = rand_op();
                y = rand_op();
                ref_mul(x, y, er, ef);
                exp_r.push_back(er);
                a = x;
                b = y;
                in_valid = 1'b1;
                sent++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end else begin
                // Busy: offer junk that must be ignored
                a = $urandom;
                b = $urandom;
                in_valid = 1'b1;
            end
        end
        checks++;
        if (recv != 20) begin
            errors++;
            $display("FAIL b2b_count got %0d want 20", recv);
        end
        @(negedge aclk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
